control_multi: RTL and testbench

- Moore/Mealy control FSM that sequences a multicycle MIPS datapath: shared memory for instructions and data, IR, MDR, A/B/ALUOut registers.
- Replaces the single-cycle opcode decoder for the multicycle build.
- Each instruction runs over 3-5 states, with a memory-ready handshake for multi-cycle memory.
- Sits beside the datapath; drives every mux select and write enable. `alu_ctl` still consumes `ALUOp`.

---
 rtl/mips_multi_pkg.sv | 43 ++++
 rtl/control_multi.sv | 155 +++++++++++++++
 tb/tb_control_multi.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/mips_multi_pkg.sv
// Shared definitions for the multicycle MIPS control path.
//   - state_t    : 4-bit state codes of the control FSM
//   - OP_*       : opcode values (IR[31:26]) the control decodes
//   - ALUOP_*, SRCB_*, PCSRC_* : select encodings driven onto the datapath
package mips_multi_pkg;

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_RTYPEEX = 4'd6,
      S_RTYPEWB = 4'd7,
      S_BEQEX   = 4'd8,
      S_JEX     = 4'd9,
      S_ADDIEX  = 4'd10,
      S_ADDIWB  = 4'd11,
      S_ILLEGAL = 4'd12
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'd0;
   localparam logic [5:0] OP_J     = 6'd2;
   localparam logic [5:0] OP_BEQ   = 6'd4;
   localparam logic [5:0] OP_ADDI  = 6'd8;
   localparam logic [5:0] OP_LW    = 6'd35;
   localparam logic [5:0] OP_SW    = 6'd43;

   localparam logic [1:0] ALUOP_ADD   = 2'd0;
   localparam logic [1:0] ALUOP_SUB   = 2'd1;
   localparam logic [1:0] ALUOP_FUNCT = 2'd2;

   localparam logic [1:0] SRCB_B      = 2'd0;
   localparam logic [1:0] SRCB_FOUR   = 2'd1;
   localparam logic [1:0] SRCB_IMM    = 2'd2;
   localparam logic [1:0] SRCB_IMMSH  = 2'd3;

   localparam logic [1:0] PCSRC_ALU    = 2'd0;
   localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
   localparam logic [1:0] PCSRC_JUMP   = 2'd2;

endpackage

// File: rtl/control_multi.sv
// Control FSM for the multicycle MIPS datapath (shared instruction/data
// memory, IR, MDR, A/B/ALUOut). Each instruction takes 3-5 states plus one
// extra cycle per memory-wait cycle.
// Ports:
//   clk, reset (async, active low)
//   opcode     : IR[31:26], used in DECODE and MEMADR
//   mem_ready  : memory finished the current access this cycle
//   PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
//   PCSource, ALUOp, ALUSrcA, ALUSrcB, RegWrite, RegDst : datapath controls
//   illegal    : unsupported opcode seen (held until reset)
//   state      : current state code
module control_multi
   import mips_multi_pkg::*;
#(
   parameter bit USE_MEM_READY = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic       mem_ready,
   output logic       PCWrite,
   output logic       PCWriteCond,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       MemtoReg,
   output logic       IRWrite,
   output logic [1:0] PCSource,
   output logic [1:0] ALUOp,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic       RegWrite,
   output logic       RegDst,
   output logic       illegal,
   output logic [3:0] state
);

   state_t state_q, state_d;
   logic   mem_rdy;

   assign mem_rdy = USE_MEM_READY ? mem_ready : 1'b1;
   assign state   = state_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= S_FETCH;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH:   if (mem_rdy) state_d = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_RTYPEEX;
               OP_BEQ:       state_d = S_BEQEX;
               OP_J:         state_d = S_JEX;
               OP_ADDI:      state_d = S_ADDIEX;
               default:      state_d = S_ILLEGAL;
            endcase
         end
         // IR can only hold lw/sw here; anything else means it was corrupted.
         S_MEMADR: begin
            if      (opcode == OP_LW) state_d = S_MEMRD;
            else if (opcode == OP_SW) state_d = S_MEMWR;
            else                      state_d = S_ILLEGAL;
         end
         S_MEMRD:   if (mem_rdy) state_d = S_MEMWB;
         S_MEMWB:   state_d = S_FETCH;
         S_MEMWR:   if (mem_rdy) state_d = S_FETCH;
         S_RTYPEEX: state_d = S_RTYPEWB;
         S_RTYPEWB: state_d = S_FETCH;
         S_BEQEX:   state_d = S_FETCH;
         S_JEX:     state_d = S_FETCH;
         S_ADDIEX:  state_d = S_ADDIWB;
         S_ADDIWB:  state_d = S_FETCH;
         S_ILLEGAL: state_d = S_ILLEGAL;
         default:   state_d = S_ILLEGAL;
      endcase
   end

   // Outputs are gated by reset so strobes drop the moment reset falls,
   // even though the cleared state (FETCH) would otherwise assert MemRead.
   always_comb begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      MemtoReg    = 1'b0;
      IRWrite     = 1'b0;
      PCSource    = PCSRC_ALU;
      ALUOp       = ALUOP_ADD;
      ALUSrcA     = 1'b0;
      ALUSrcB     = SRCB_B;
      RegWrite    = 1'b0;
      RegDst      = 1'b0;
      illegal     = 1'b0;
      if (reset) begin
         case (state_q)
            S_FETCH: begin
               MemRead = 1'b1;
               ALUSrcB = SRCB_FOUR;
               // PC+4 and IR load only in the cycle the fetch completes.
               IRWrite = mem_rdy;
               PCWrite = mem_rdy;
            end
            S_DECODE:  ALUSrcB = SRCB_IMMSH;
            S_MEMADR: begin
               ALUSrcA = 1'b1;
               ALUSrcB = SRCB_IMM;
            end
            S_MEMRD: begin
               MemRead = 1'b1;
               IorD    = 1'b1;
            end
            S_MEMWB: begin
               RegWrite = 1'b1;
               MemtoReg = 1'b1;
            end
            S_MEMWR: begin
               MemWrite = 1'b1;
               IorD     = 1'b1;
            end
            S_RTYPEEX: begin
               ALUSrcA = 1'b1;
               ALUOp   = ALUOP_FUNCT;
            end
            S_RTYPEWB: begin
               RegWrite = 1'b1;
               RegDst   = 1'b1;
            end
            S_BEQEX: begin
               ALUSrcA     = 1'b1;
               ALUOp       = ALUOP_SUB;
               PCWriteCond = 1'b1;
               PCSource    = PCSRC_ALUOUT;
            end
            S_JEX: begin
               PCWrite  = 1'b1;
               PCSource = PCSRC_JUMP;
            end
            S_ADDIEX: begin
               ALUSrcA = 1'b1;
               ALUSrcB = SRCB_IMM;
            end
            S_ADDIWB:  RegWrite = 1'b1;
            S_ILLEGAL: illegal  = 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_control_multi.sv
// Randomized bench for control_multi. The stimulus process walks whole
// instructions (random opcodes, random memory waits, random don't-care
// inputs) and pushes the expected control word of every cycle into a queue;
// a monitor pops one entry per cycle and compares it against the DUT.
module tb_control_multi;

   typedef logic [20:0] vec_t;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [5:0] opcode = 6'd0;
   logic       mem_ready = 1'b1;
   logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite;
   logic [1:0] PCSource, ALUOp, ALUSrcB;
   logic       ALUSrcA, RegWrite, RegDst, illegal;
   logic [3:0] state;

   int n_cmp = 0;
   int n_bad = 0;
   vec_t exp_q[$];

   control_multi #(.USE_MEM_READY(1'b1)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
      .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
      .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
      .IRWrite(IRWrite), .PCSource(PCSource), .ALUOp(ALUOp),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .RegWrite(RegWrite),
      .RegDst(RegDst), .illegal(illegal), .state(state)
   );

   always #5 clk = ~clk;

   // Expected control word; every field not named is 0.
   function automatic vec_t ex(
      input bit [3:0] st = 0, input bit pcw = 0, input bit pcwc = 0,
      input bit iord = 0, input bit mrd = 0, input bit mwr = 0,
      input bit m2r = 0, input bit irw = 0, input bit [1:0] pcs = 0,
      input bit [1:0] aop = 0, input bit sa = 0, input bit [1:0] sb = 0,
      input bit rw = 0, input bit rd = 0, input bit ill = 0);
      return {pcw, pcwc, iord, mrd, mwr, m2r, irw, pcs, aop, sa, sb, rw, rd, ill, st};
   endfunction

   // Drive one cycle's inputs just after the edge and record what the DUT
   // must show during that cycle.
   task automatic step(input logic rst, input logic [5:0] op, input logic mr, input vec_t e);
      @(posedge clk);
      #1;
      reset     = rst;
      opcode    = op;
      mem_ready = mr;
      exp_q.push_back(e);
   endtask

   function automatic logic [5:0] rnd_op();
      return 6'($urandom_range(0, 63));
   endfunction

   function automatic logic rnd_bit();
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic rst_cycles(input int n);
      for (int i = 0; i < n; i++) step(1'b0, rnd_op(), rnd_bit(), ex());
   endtask

   // Memory phase: w wait cycles then the completing cycle.
   task automatic mem_phase(input logic [5:0] op, input int w, input vec_t wait_e, input vec_t done_e);
      for (int i = 0; i < w; i++) step(1'b1, op, 1'b0, wait_e);
      step(1'b1, op, 1'b1, done_e);
   endtask

   task automatic fetch(input int w);
      for (int i = 0; i < w; i++) step(1'b1, rnd_op(), 1'b0, ex(.st(0), .mrd(1), .sb(1)));
      step(1'b1, rnd_op(), 1'b1, ex(.st(0), .mrd(1), .sb(1), .irw(1), .pcw(1)));
   endtask

   // One full instruction from FETCH back to (but excluding) the next FETCH.
   task automatic run_instr(input logic [5:0] op, input int maxw);
      fetch($urandom_range(0, maxw));
      step(1'b1, op, rnd_bit(), ex(.st(1), .sb(3)));
      case (op)
         6'd35: begin
            step(1'b1, op, rnd_bit(), ex(.st(2), .sa(1), .sb(2)));
            mem_phase(op, $urandom_range(0, maxw), ex(.st(3), .iord(1), .mrd(1)), ex(.st(3), .iord(1), .mrd(1)));
            step(1'b1, rnd_op(), rnd_bit(), ex(.st(4), .rw(1), .m2r(1)));
         end
         6'd43: begin
            step(1'b1, op, rnd_bit(), ex(.st(2), .sa(1), .sb(2)));
            mem_phase(op, $urandom_range(0, maxw), ex(.st(5), .iord(1), .mwr(1)), ex(.st(5), .iord(1), .mwr(1)));
         end
         6'd0: begin
            step(1'b1, rnd_op(), rnd_bit(), ex(.st(6), .sa(1), .aop(2)));
            step(1'b1, rnd_op(), rnd_bit(), ex(.st(7), .rw(1), .rd(1)));
         end
         6'd4: step(1'b1, rnd_op(), rnd_bit(), ex(.st(8), .sa(1), .aop(1), .pcwc(1), .pcs(1)));
         6'd2: step(1'b1, rnd_op(), rnd_bit(), ex(.st(9), .pcw(1), .pcs(2)));
         6'd8: begin
            step(1'b1, rnd_op(), rnd_bit(), ex(.st(10), .sa(1), .sb(2)));
            step(1'b1, rnd_op(), rnd_bit(), ex(.st(11), .rw(1)));
         end
         default: begin
            // Unsupported opcode: stuck until reset, then restart cleanly.
            for (int i = 0; i < 20; i++) step(1'b1, rnd_op(), rnd_bit(), ex(.st(12), .ill(1)));
            rst_cycles(1 + $urandom_range(0, 1));
         end
      endcase
   endtask

   // Monitor: one expected word per cycle, sampled mid-cycle.
   always @(negedge clk) begin
      vec_t got, e;
      if (exp_q.size() > 0) begin
         e   = exp_q.pop_front();
         got = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
                PCSource, ALUOp, ALUSrcA, ALUSrcB, RegWrite, RegDst, illegal, state};
         n_cmp++;
         if (got !== e) begin
            n_bad++;
            $display("FAIL ctrl_word t=%0t state got=%0d exp=%0d word got=%h exp=%h",
                     $time, got[3:0], e[3:0], got, e);
         end
      end
   end

   localparam logic [5:0] LEGAL [6] = '{6'd0, 6'd2, 6'd4, 6'd8, 6'd35, 6'd43};

   initial begin
      logic [5:0] op;
      // Reset held two cycles, then plain fetch.
      rst_cycles(2);
      run_instr(6'd35, 0);
      // sw with a 3-cycle write wait, fetch with a 2-cycle wait.
      fetch(2);
      step(1'b1, 6'd43, 1'b1, ex(.st(1), .sb(3)));
      step(1'b1, 6'd43, 1'b1, ex(.st(2), .sa(1), .sb(2)));
      mem_phase(6'd43, 3, ex(.st(5), .iord(1), .mwr(1)), ex(.st(5), .iord(1), .mwr(1)));
      run_instr(6'd4, 0);
      run_instr(6'd2, 0);
      run_instr(6'd63, 0);
      // Opcode corrupted between DECODE and MEMADR.
      fetch(0);
      step(1'b1, 6'd35, 1'b1, ex(.st(1), .sb(3)));
      step(1'b1, 6'd0, 1'b1, ex(.st(2), .sa(1), .sb(2)));
      step(1'b1, rnd_op(), rnd_bit(), ex(.st(12), .ill(1)));
      rst_cycles(1);
      // Reset mid-instruction during RTYPEEX.
      fetch(1);
      step(1'b1, 6'd0, 1'b1, ex(.st(1), .sb(3)));
      step(1'b1, 6'd0, 1'b1, ex(.st(6), .sa(1), .aop(2)));
      rst_cycles(1);
      // Random traffic.
      for (int n = 0; n < 80; n++) begin
         if ($urandom_range(0, 15) == 0) begin
            do op = rnd_op();
            while (op inside {6'd0, 6'd2, 6'd4, 6'd8, 6'd35, 6'd43});
         end else begin
            op = LEGAL[$urandom_range(0, 5)];
         end
         run_instr(op, 3);
      end
      step(1'b1, rnd_op(), 1'b0, ex(.st(0), .mrd(1), .sb(1)));
      @(posedge clk);
      @(negedge clk);
      #1;
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain leftover=%0d required=0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
